// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-control stage: run/halt sequencing and next-PC select (inc / abs / rel branch).
// Latency: one register; the decision taken in cycle N appears on pc/running/done in cycle N+1.
// Backpressure: stall=1 in RUN freezes the PC and suppresses branches; optional counter via PC_BR_COUNT_EN.
module pc_fetch_ctrl #(
    parameter int D  = 10,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         halt,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [D-1:0] br_target,
    output logic [D-1:0] pc,
    output logic         running,
`ifdef PC_BR_COUNT_EN
    output logic         done,
    output logic [CW-1:0] br_count
`else
    output logic         done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [D-1:0] PC_ONE = D'(1);

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         running_q, running_d;
    logic         done_q, done_d;

    // Next-state and next-PC selection; priority in RUN is halt > stall > branch > increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch_en) begin
                    pc_d = branch_rel ? (pc_q + br_target) : br_target;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALT);
    end

    // State, PC and status flops; reset is synchronous and overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;

`ifdef PC_BR_COUNT_EN
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] br_cnt_q, br_cnt_d;

    // Taken-branch counter: cleared by an accepted start, saturates at all-ones.
    always_comb begin
        br_cnt_d = br_cnt_q;
        if ((state_q == ST_IDLE || state_q == ST_HALT) && start) begin
            br_cnt_d = '0;
        end else if (state_q == ST_RUN && !halt && !stall && branch_en && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            br_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    assign br_count = br_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against a behavioural model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
// A narrow counter width is used so saturation is reachable when PC_BR_COUNT_EN is defined.
module tb_pc_fetch_ctrl;

    localparam int D     = 10;
    localparam int TB_CW = 4;
    localparam int MOD   = 1 << D;
    localparam int CMAX  = (1 << TB_CW) - 1;

    logic         clk = 1'b0;
    logic         reset, start, halt, stall, branch_en, branch_rel;
    logic [D-1:0] br_target;
    logic [D-1:0] pc;
    logic         running, done;
`ifdef PC_BR_COUNT_EN
    logic [TB_CW-1:0] br_count;
`endif

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.D(D), .CW(TB_CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_rel (branch_rel),
        .br_target  (br_target),
        .pc         (pc),
        .running    (running),
`ifdef PC_BR_COUNT_EN
        .done       (done),
        .br_count   (br_count)
`else
        .done       (done)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: mode 0 = idle, 1 = run, 2 = halt.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".running"}, 32'(running), 32'(m_mode == 1));
        chk({tag, ".done"}, 32'(done), 32'(m_mode == 2));
`ifdef PC_BR_COUNT_EN
        chk({tag, ".br_count"}, 32'(br_count), 32'(m_cnt));
`endif
    endtask

    task automatic model_step(input logic r, input logic st, input logic h, input logic s,
                              input logic be, input logic rel, input int tgt);
        if (!r) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode = 1; m_cnt = 0;
            end
        end else if (m_mode == 1) begin
            if (h) begin
                m_mode = 2;
            end else if (s) begin
                m_pc = m_pc;
            end else if (be) begin
                m_pc = rel ? (m_pc + tgt) % MOD : tgt;
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end else begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare on the falling edge.
    task automatic step(input string tag, input logic r, input logic st, input logic h, input logic s,
                        input logic be, input logic rel, input int tgt);
        reset = r; start = st; halt = h; stall = s;
        branch_en = be; branch_rel = rel; br_target = tgt[D-1:0];
        @(posedge clk);
        model_step(r, st, h, s, be, rel, tgt);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        // Reset and launch: pc counts 0..5 from address 0.
        step("rst0", 1'b0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1'b0, 0, 0, 0, 1, 0, 7);
        step("idle", 1'b1, 0, 0, 0, 1, 0, 9);
        step("start", 1'b1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("inc", 1'b1, 0, 0, 0, 0, 0, 0);
        step("start_in_run", 1'b1, 1, 0, 0, 0, 0, 0);

        // Absolute branch from pc=3 to 44, then sequential.
        step("rst2", 1'b0, 0, 0, 0, 0, 0, 0);
        step("start2", 1'b1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("inc2", 1'b1, 0, 0, 0, 0, 0, 0);
        step("abs44", 1'b1, 0, 0, 0, 1, 0, 44);
        step("inc45", 1'b1, 0, 0, 0, 0, 0, 0);
        step("inc46", 1'b1, 0, 0, 0, 0, 0, 0);

        // Relative branches: negative offset and positive offset, back to back.
        step("abs4", 1'b1, 0, 0, 0, 1, 0, 4);
        step("rel_neg", 1'b1, 0, 0, 0, 1, 1, 'h3FF);
        step("abs84", 1'b1, 0, 0, 0, 1, 0, 84);
        step("rel20", 1'b1, 0, 0, 0, 1, 1, 20);

        // Wrap-around on increment and on relative add.
        step("abs1023", 1'b1, 0, 0, 0, 1, 0, 1023);
        step("wrap_inc", 1'b1, 0, 0, 0, 0, 0, 0);
        step("abs1020", 1'b1, 0, 0, 0, 1, 0, 1020);
        step("wrap_rel", 1'b1, 0, 0, 0, 1, 1, 5);

        // Stall beats branch; halt beats branch; halt ignores inputs; restart from HALT.
        step("abs10", 1'b1, 0, 0, 0, 1, 0, 10);
        step("stall_br", 1'b1, 0, 0, 1, 1, 0, 300);
        step("inc11", 1'b1, 0, 0, 0, 0, 0, 0);
        step("inc12", 1'b1, 0, 0, 0, 0, 0, 0);
        step("halt_br", 1'b1, 0, 1, 0, 1, 0, 500);
        step("halt_hold", 1'b1, 0, 1, 1, 1, 1, 77);
        step("restart", 1'b1, 1, 0, 0, 0, 0, 0);

        // Three taken branches, then reset mid-run at pc=50 with a branch pending.
        step("br48", 1'b1, 0, 0, 0, 1, 0, 48);
        step("br49", 1'b1, 0, 0, 0, 1, 1, 1);
        step("br50", 1'b1, 0, 0, 0, 1, 0, 50);
        step("rst_mid", 1'b0, 0, 0, 0, 1, 0, 200);
        step("idle_hold", 1'b1, 0, 0, 0, 1, 0, 33);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 logic'($urandom_range(0, 79) != 0),
                 logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 4) == 0),
                 logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 1)),
                 int'($urandom_range(0, MOD - 1)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
